tx_symbol_scheduler: RTL and testbench
======================================

TX_SYMBOL_SCHEDULER -- requirements
Module: tx_symbol_scheduler

Interface
REQ-001 SPS, default 3, clock cycles per symbol strobe; legal range 2..15.
REQ-002 DEPTH, default 4, input FIFO entries; power of two, 2..16.
REQ-003 PRE_LEN, default 8, preamble symbols per frame; legal range 1..63.
REQ-004 FLUSH_LEN, default 11, zero symbols emitted after the last data symbol; sized as ceil(31/SPS) to drain the 31-tap shaping filter.
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 in_data  input  16  signed symbol from the encoder.
REQ-008 in_last  input  1  marks the final symbol of a frame.
REQ-009 in_valid  input  1  in_data and in_last are valid.
REQ-010 in_ready  output  1  FIFO can accept one entry.
REQ-011 sym_out  output  16  registered symbol to the pulse-shaping filter.
REQ-012 sym_valid  output  1  one-cycle strobe; sym_out is new this cycle.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 frame_done  output  1  one-cycle pulse at the end of FLUSH.
REQ-015 underrun  output  1  sticky flag; a data strobe found the FIFO empty.

Function
REQ-016 A push SHALL occur when in_valid and in_ready are both high; in_ready SHALL equal NOT full, using registered FIFO state.
REQ-017 FIFO entries SHALL be 17 bits wide ({in_last, in_data}), with wrap-around read and write pointers and an occupancy count of width log2(DEPTH)+1.
REQ-018 A pushed entry SHALL first be poppable on the cycle after the push; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-019 The symbol counter SHALL be held at 0 in IDLE, count 0..SPS-1 in every other state, and wrap to 0 after SPS-1.
REQ-020 A strobe SHALL occur when the counter equals SPS-1; on each strobe the block SHALL drive sym_valid=1 for one cycle and load sym_out, and sym_out SHALL hold its value between strobes.
REQ-021 State machine, 2-bit encoding, states IDLE, PREAMBLE, DATA, FLUSH.
REQ-022 IDLE -> PREAMBLE when the FIFO is non-empty; the preamble symbol counter SHALL clear on this transition.
REQ-023 In PREAMBLE, strobe k (k = 0..PRE_LEN-1) SHALL output 16'h0001 for even k and 16'hFFFF for odd k. After strobe PRE_LEN-1 the state SHALL move to DATA.
REQ-024 In DATA, each strobe SHALL pop one entry and output its data.
REQ-025 If a DATA strobe finds the FIFO empty, the block SHALL output 16'h0000, set underrun, and remain in DATA.
REQ-026 A pop whose last bit is 1 SHALL move the state to FLUSH after that strobe, and the flush symbol counter SHALL clear.
REQ-027 In FLUSH, each strobe SHALL output 16'h0000 and no pops SHALL occur. After FLUSH_LEN strobes the block SHALL pulse frame_done for one cycle, coincident with the last flush strobe, and enter IDLE.
REQ-028 Pushes SHALL remain allowed in every state, so the next frame can pre-fill the FIFO during FLUSH.
REQ-029 If the FIFO is non-empty on return to IDLE, PREAMBLE SHALL start on the next cycle.
REQ-030 A strobe SHALL pop at most one entry; entries with in_last=1 arriving back-to-back SHALL each form a separate frame.

Reset
REQ-031 While reset=0 at a clock edge, the block SHALL enter IDLE, clear the counters and FIFO pointers, and drive in_ready=0, sym_out=0, sym_valid=0, busy=0, frame_done=0, underrun=0.
REQ-032 On the first edge with reset=1, in_ready SHALL go to 1.
REQ-033 A reset asserted mid-frame SHALL discard all FIFO contents and the in-progress frame, and SHALL clear the underrun flag.

Verification
REQ-034 Reset then push 3 symbols (5, -5, 7, last on 7) at defaults -> 8 preamble strobes 1,-1,...,-1 spaced 3 cycles apart; then 5, -5, 7; then 11 zero strobes; frame_done on the 22nd strobe; busy low the next cycle.
REQ-035 Hold in_valid=1 with no frame started, DEPTH=4 -> exactly 4 pushes accepted and in_ready=0 from the cycle after the 4th push. The frame then starts (REQ-022), and in_ready returns to 1 on the cycle after the first DATA pop.
REQ-036 Push 1 symbol without last, then stop -> after the preamble, data strobe 1 outputs the symbol, strobe 2 outputs 0 with underrun=1, and the block stays busy. A later push with last=1 completes the frame normally, and underrun remains 1.
REQ-037 Assert reset=0 for one cycle during DATA with 2 entries queued -> all outputs reach reset values on that edge, FIFO is empty, and no strobe occurs afterward until a new push.
REQ-038 Push frame A (last) and then frame B during A's FLUSH -> frame_done for A, one IDLE cycle, then B's preamble starts with correct spacing.
REQ-039 SPS=2, PRE_LEN=1, FLUSH_LEN=1, single last symbol -> strobes at cycles 2, 4, 6 after leaving IDLE carry 1, data, 0; frame_done on the third strobe.

Source files
------------

// File: rtl/tx_symbol_scheduler_if.sv
// ============================================================================
// Module      : tx_symbol_scheduler_if
// Description : Encoder-side push bus and filter-side symbol bus of the
//               TX symbol scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tx_symbol_scheduler_if;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sym_out;
    logic        sym_valid;
    logic        busy;
    logic        frame_done;
    logic        underrun;

    modport master (
        output in_data, in_last, in_valid,
        input  in_ready, sym_out, sym_valid, busy, frame_done, underrun
    );

    modport slave (
        input  in_data, in_last, in_valid,
        output in_ready, sym_out, sym_valid, busy, frame_done, underrun
    );
endinterface

`default_nettype wire

// File: rtl/tx_symbol_scheduler.sv
// ============================================================================
// Module      : tx_symbol_scheduler
// Description : Buffers encoder symbols and emits preamble, data and filter
//               flush symbols on a fixed symbol-rate strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_symbol_scheduler #(
    parameter int SPS       = 3,
    parameter int DEPTH     = 4,
    parameter int PRE_LEN   = 8,
    parameter int FLUSH_LEN = 11
) (
    input  wire logic          clk,
    input  wire logic          reset,
    tx_symbol_scheduler_if.slave bus
);

    localparam int               c_AW         = $clog2(DEPTH);
    localparam logic [c_AW-1:0]  c_PTR_ONE    = c_AW'(1);
    localparam logic [c_AW:0]    c_CNT_ONE    = (c_AW+1)'(1);
    localparam logic [c_AW:0]    c_FULL       = (c_AW+1)'(DEPTH);
    localparam logic [3:0]       c_SYM_LAST   = 4'(SPS - 1);
    localparam logic [5:0]       c_PRE_LAST   = 6'(PRE_LEN - 1);
    localparam logic [5:0]       c_FLUSH_LAST = 6'(FLUSH_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_DATA     = 2'd2,
        S_FLUSH    = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic [3:0]        sym_cnt_q,   sym_cnt_d;
    logic [5:0]        pre_cnt_q,   pre_cnt_d;
    logic [5:0]        flush_cnt_q, flush_cnt_d;
    logic [15:0]       sym_out_q,   sym_out_d;
    logic              sym_valid_q, sym_valid_d;
    logic              busy_q,      busy_d;
    logic              frame_done_q, frame_done_d;
    logic              underrun_q,  underrun_d;
    logic              in_ready_q,  in_ready_d;
    logic [c_AW-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [c_AW-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [c_AW:0]     count_q,     count_d;
    logic [16:0]       mem_q [DEPTH];

    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_strobe;
    logic [16:0]       w_head;

    assign w_push   = bus.in_valid & in_ready_q;
    assign w_empty  = (count_q == '0);
    assign w_strobe = (state_q != S_IDLE) && (sym_cnt_q == c_SYM_LAST);
    assign w_head   = mem_q[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        sym_out_d    = sym_out_q;
        sym_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = underrun_q;
        w_pop        = 1'b0;

        // Counter free-runs through all non-idle states so strobe spacing is
        // unbroken across PREAMBLE/DATA/FLUSH boundaries.
        if (state_q == S_IDLE || w_strobe) begin
            sym_cnt_d = 4'd0;
        end else begin
            sym_cnt_d = sym_cnt_q + 4'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    state_d   = S_PREAMBLE;
                    pre_cnt_d = 6'd0;
                end
            end
            S_PREAMBLE: begin
                if (w_strobe) begin
                    sym_valid_d = 1'b1;
                    sym_out_d   = pre_cnt_q[0] ? 16'hFFFF : 16'h0001;
                    pre_cnt_d   = pre_cnt_q + 6'd1;
                    if (pre_cnt_q == c_PRE_LAST) begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_strobe) begin
                    sym_valid_d = 1'b1;
                    if (w_empty) begin
                        sym_out_d  = 16'h0000;
                        underrun_d = 1'b1;
                    end else begin
                        w_pop     = 1'b1;
                        sym_out_d = w_head[15:0];
                        if (w_head[16]) begin
                            state_d     = S_FLUSH;
                            flush_cnt_d = 6'd0;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (w_strobe) begin
                    sym_valid_d = 1'b1;
                    sym_out_d   = 16'h0000;
                    flush_cnt_d = flush_cnt_q + 6'd1;
                    if (flush_cnt_q == c_FLUSH_LAST) begin
                        state_d      = S_IDLE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase
        in_ready_d = (count_d != c_FULL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            sym_cnt_q    <= 4'd0;
            pre_cnt_q    <= 6'd0;
            flush_cnt_q  <= 6'd0;
            sym_out_q    <= 16'h0000;
            sym_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            sym_cnt_q    <= sym_cnt_d;
            pre_cnt_q    <= pre_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            sym_out_q    <= sym_out_d;
            sym_valid_q  <= sym_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
            in_ready_q   <= in_ready_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: the cleared pointers and count make it invisible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {bus.in_last, bus.in_data};
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.sym_out    = sym_out_q;
    assign bus.sym_valid  = sym_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.underrun   = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_symbol_scheduler.sv
// ============================================================================
// Module      : tb_tx_symbol_scheduler
// Description : Directed self-checking bench for tx_symbol_scheduler at the
//               default parameters and at SPS=2/PRE_LEN=1/FLUSH_LEN=1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_symbol_scheduler;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    tx_symbol_scheduler_if bi ();
    tx_symbol_scheduler_if bi2 ();

    tx_symbol_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bi)
    );

    tx_symbol_scheduler #(
        .SPS       (2),
        .DEPTH     (4),
        .PRE_LEN   (1),
        .FLUSH_LEN (1)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bi2)
    );

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic        fd;
        logic        busy;
        logic        ur;
    } strobe_t;

    strobe_t q[$];
    strobe_t q2[$];
    strobe_t ms, ms2;
    int   cyc        = 0;
    int   busy_rise  = 0;
    int   busy_rise2 = 0;
    int   fd_count   = 0;
    logic busy_prev  = 1'b0;
    logic busy_prev2 = 1'b0;
    int   total      = 0;
    int   bad        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log, sampled on the falling edge
    always @(negedge clk) begin
        if (bi.busy === 1'b1 && busy_prev !== 1'b1) busy_rise = cyc;
        busy_prev = bi.busy;
        if (bi2.busy === 1'b1 && busy_prev2 !== 1'b1) busy_rise2 = cyc;
        busy_prev2 = bi2.busy;
        if (bi.frame_done === 1'b1) fd_count++;
        if (bi.sym_valid === 1'b1) begin
            ms.cyc = cyc; ms.data = bi.sym_out; ms.fd = bi.frame_done;
            ms.busy = bi.busy; ms.ur = bi.underrun;
            q.push_back(ms);
        end
        if (bi2.sym_valid === 1'b1) begin
            ms2.cyc = cyc; ms2.data = bi2.sym_out; ms2.fd = bi2.frame_done;
            ms2.busy = bi2.busy; ms2.ur = bi2.underrun;
            q2.push_back(ms2);
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        bi.in_valid  = 1'b0;
        bi2.in_valid = 1'b0;
        reset = 1'b0;
        tick; tick;
        reset = 1'b1;
        tick;
    endtask

    task automatic push(input logic [15:0] d, input logic l);
        bi.in_data  = d;
        bi.in_last  = l;
        bi.in_valid = 1'b1;
        for (int g = 0; g < 500 && bi.in_ready !== 1'b1; g++) tick;
        tick;
        bi.in_valid = 1'b0;
    endtask

    task automatic wait_q(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && q.size() < n; i++) tick;
        ok = (q.size() >= n);
    endtask

    task automatic wait_fd(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && fd_count < n; i++) tick;
        ok = (fd_count >= n);
    endtask

    task automatic test_reset;
        bi.in_valid = 1'b0; bi.in_data = '0; bi.in_last = 1'b0;
        bi2.in_valid = 1'b0; bi2.in_data = '0; bi2.in_last = 1'b0;
        reset = 1'b0;
        tick; tick;
        total++;
        if ({bi.in_ready, bi.sym_valid, bi.busy, bi.frame_done, bi.underrun} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {bi.in_ready, bi.sym_valid, bi.busy, bi.frame_done, bi.underrun});
        end
        total++;
        if (bi.sym_out !== 16'h0000) begin
            bad++; $display("FAIL reset_sym_out: got %h want 0000", bi.sym_out);
        end
        reset = 1'b1;
        tick;
        total++;
        if (bi.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready: got %b want 1", bi.in_ready);
        end
    endtask

    task automatic test_frame;
        logic [15:0] exp [22];
        bit ok;
        do_reset;
        q.delete();
        for (int i = 0; i < 22; i++) exp[i] = 16'h0000;
        for (int i = 0; i < 8; i++) exp[i] = (i % 2 == 1) ? 16'hFFFF : 16'h0001;
        exp[8] = 16'h0005; exp[9] = 16'hFFFB; exp[10] = 16'h0007;
        push(16'h0005, 1'b0);
        push(16'hFFFB, 1'b0);
        push(16'h0007, 1'b1);
        wait_q(22, 300, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL frame_timeout: got %0d strobes want 22", q.size());
        end else begin
            total++;
            if (q[0].cyc - busy_rise != 3) begin
                bad++; $display("FAIL frame_first_gap: got %0d want 3", q[0].cyc - busy_rise);
            end
            for (int i = 0; i < 22; i++) begin
                total++;
                if (q[i].data !== exp[i]) begin
                    bad++; $display("FAIL frame_data[%0d]: got %h want %h", i, q[i].data, exp[i]);
                end
                total++;
                if (q[i].fd !== (i == 21)) begin
                    bad++; $display("FAIL frame_done[%0d]: got %b want %b", i, q[i].fd, i == 21);
                end
                if (i > 0) begin
                    total++;
                    if (q[i].cyc - q[i-1].cyc != 3) begin
                        bad++; $display("FAIL frame_spacing[%0d]: got %0d want 3", i, q[i].cyc - q[i-1].cyc);
                    end
                end
            end
            tick;
            total++;
            if (bi.busy !== 1'b0) begin
                bad++; $display("FAIL frame_busy_after: got %b want 0", bi.busy);
            end
            total++;
            if (q.size() != 22) begin
                bad++; $display("FAIL frame_extra_strobes: got %0d want 22", q.size());
            end
        end
    endtask

    task automatic test_fifo_full;
        int  pushes;
        bit  took;
        do_reset;
        q.delete();
        pushes = 0;
        bi.in_last  = 1'b0;
        bi.in_data  = 16'd100;
        bi.in_valid = 1'b1;
        for (int t = 0; t < 300 && q.size() < 9; t++) begin
            took = (bi.in_ready === 1'b1);
            tick;
            if (took) begin
                pushes++;
                bi.in_data = 16'd100 + 16'(pushes);
                if (pushes == 4) begin
                    total++;
                    if (bi.in_ready !== 1'b0) begin
                        bad++; $display("FAIL full_ready_low: got %b want 0", bi.in_ready);
                    end
                end
            end
        end
        total++;
        if (pushes != 4) begin
            bad++; $display("FAIL full_push_count: got %0d want 4", pushes);
        end
        total++;
        if (bi.in_ready !== 1'b1) begin
            bad++; $display("FAIL full_ready_return: got %b want 1", bi.in_ready);
        end
        bi.in_valid = 1'b0;
        total++;
        if (q.size() < 9) begin
            bad++; $display("FAIL full_timeout: got %0d strobes want 9", q.size());
        end else begin
            total++;
            if (q[8].data !== 16'd100) begin
                bad++; $display("FAIL full_first_data: got %h want 0064", q[8].data);
            end
        end
    endtask

    task automatic test_underrun;
        bit ok;
        int fd0, idx;
        do_reset;
        q.delete();
        fd0 = fd_count;
        push(16'h0042, 1'b0);
        wait_q(10, 300, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL under_timeout: got %0d strobes want 10", q.size());
        end else begin
            total++;
            if (q[8].data !== 16'h0042 || q[8].ur !== 1'b0) begin
                bad++; $display("FAIL under_data1: got %h/%b want 0042/0", q[8].data, q[8].ur);
            end
            total++;
            if (q[9].data !== 16'h0000 || q[9].ur !== 1'b1) begin
                bad++; $display("FAIL under_data2: got %h/%b want 0000/1", q[9].data, q[9].ur);
            end
        end
        for (int i = 0; i < 5; i++) tick;
        total++;
        if (bi.busy !== 1'b1) begin
            bad++; $display("FAIL under_busy: got %b want 1", bi.busy);
        end
        push(16'h0033, 1'b1);
        wait_fd(fd0 + 1, 300, ok);
        idx = -1;
        for (int i = 10; i < q.size(); i++) if (q[i].data === 16'h0033) idx = i;
        total++;
        if (!ok || idx < 0) begin
            bad++; $display("FAIL under_complete: got done=%b idx=%0d want done=1 idx>=10", ok, idx);
        end else begin
            total++;
            if (q.size() - 1 - idx != 11 || q[q.size()-1].fd !== 1'b1) begin
                bad++; $display("FAIL under_flush: got %0d flush strobes want 11", q.size() - 1 - idx);
            end
        end
        total++;
        if (bi.underrun !== 1'b1) begin
            bad++; $display("FAIL under_sticky: got %b want 1", bi.underrun);
        end
        reset = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        total++;
        if (bi.underrun !== 1'b0) begin
            bad++; $display("FAIL under_reset_clear: got %b want 0", bi.underrun);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        do_reset;
        q.delete();
        push(16'h0001, 1'b0);
        push(16'h0002, 1'b0);
        push(16'h0003, 1'b0);
        wait_q(9, 300, ok);
        total++;
        if (!ok || q[8].data !== 16'h0001) begin
            bad++; $display("FAIL mid_first_data: got ok=%b want ok=1 data 0001", ok);
        end
        reset = 1'b0;
        tick;
        total++;
        if ({bi.in_ready, bi.sym_valid, bi.busy, bi.frame_done, bi.underrun} !== 5'b0 ||
            bi.sym_out !== 16'h0000) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %b/%h want 00000/0000",
                     {bi.in_ready, bi.sym_valid, bi.busy, bi.frame_done, bi.underrun}, bi.sym_out);
        end
        reset = 1'b1;
        q.delete();
        for (int i = 0; i < 40; i++) tick;
        total++;
        if (q.size() != 0 || bi.busy !== 1'b0 || bi.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_after_idle: got strobes=%0d busy=%b ready=%b want 0/0/1",
                     q.size(), bi.busy, bi.in_ready);
        end
        push(16'h0021, 1'b1);
        wait_q(9, 300, ok);
        total++;
        if (!ok || q[8].data !== 16'h0021) begin
            bad++; $display("FAIL mid_new_frame: got ok=%b want ok=1 data 0021", ok);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int fd0;
        do_reset;
        q.delete();
        fd0 = fd_count;
        push(16'h000A, 1'b1);
        wait_q(9, 300, ok);
        push(16'h000B, 1'b1);
        wait_fd(fd0 + 2, 400, ok);
        total++;
        if (!ok || q.size() != 40) begin
            bad++; $display("FAIL b2b_count: got %0d strobes want 40", q.size());
        end else begin
            total++;
            if (q[8].data !== 16'h000A || q[28].data !== 16'h000B) begin
                bad++; $display("FAIL b2b_data: got %h,%h want 000a,000b", q[8].data, q[28].data);
            end
            total++;
            if (q[19].fd !== 1'b1 || q[39].fd !== 1'b1) begin
                bad++; $display("FAIL b2b_done: got %b,%b want 1,1", q[19].fd, q[39].fd);
            end
            total++;
            if (busy_rise != q[19].cyc + 1) begin
                bad++; $display("FAIL b2b_idle_gap: got %0d want %0d", busy_rise, q[19].cyc + 1);
            end
            total++;
            if (q[20].cyc - q[19].cyc != 4 || q[20].data !== 16'h0001) begin
                bad++;
                $display("FAIL b2b_preamble: got gap=%0d data=%h want gap=4 data=0001",
                         q[20].cyc - q[19].cyc, q[20].data);
            end
            total++;
            if (q[21].cyc - q[20].cyc != 3 || q[21].data !== 16'hFFFF) begin
                bad++;
                $display("FAIL b2b_spacing: got gap=%0d data=%h want gap=3 data=ffff",
                         q[21].cyc - q[20].cyc, q[21].data);
            end
        end
    endtask

    task automatic test_sps2;
        do_reset;
        q2.delete();
        bi2.in_data  = 16'h0055;
        bi2.in_last  = 1'b1;
        bi2.in_valid = 1'b1;
        tick;
        bi2.in_valid = 1'b0;
        for (int i = 0; i < 50 && q2.size() < 3; i++) tick;
        total++;
        if (q2.size() < 3) begin
            bad++; $display("FAIL sps2_timeout: got %0d strobes want 3", q2.size());
        end else begin
            total++;
            if (q2[0].cyc - busy_rise2 != 2 || q2[1].cyc - busy_rise2 != 4 ||
                q2[2].cyc - busy_rise2 != 6) begin
                bad++;
                $display("FAIL sps2_timing: got %0d,%0d,%0d want 2,4,6", q2[0].cyc - busy_rise2,
                         q2[1].cyc - busy_rise2, q2[2].cyc - busy_rise2);
            end
            total++;
            if (q2[0].data !== 16'h0001 || q2[1].data !== 16'h0055 || q2[2].data !== 16'h0000) begin
                bad++;
                $display("FAIL sps2_data: got %h,%h,%h want 0001,0055,0000",
                         q2[0].data, q2[1].data, q2[2].data);
            end
            total++;
            if ({q2[0].fd, q2[1].fd, q2[2].fd} !== 3'b001) begin
                bad++; $display("FAIL sps2_done: got %b want 001", {q2[0].fd, q2[1].fd, q2[2].fd});
            end
        end
    endtask

    initial begin
        test_reset;
        test_frame;
        test_fifo_full;
        test_underrun;
        test_reset_mid;
        test_back_to_back;
        test_sps2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
